// File: rtl/split_pkg.sv
// rtl/split_pkg.sv - shared state type, width helpers and default sizes for the split evaluator
package split_pkg;

  localparam int DEF_VAR_W = 32;
  localparam int DEF_ACC_W = 40;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Beat counter width able to hold 0 .. n+1 (the overrun beat is counted).
  function automatic int count_w(input int n);
    return $clog2(n + 1) + 1;
  endfunction

  // Width of a field able to hold 0 .. var_w.
  function automatic int width_w(input int var_w);
    return $clog2(var_w + 1);
  endfunction

endpackage

// File: rtl/split_mask_acc.sv
// rtl/split_mask_acc.sv - width masking and saturating accumulate of one beat; parity under SPLIT_PARITY_EN
module split_mask_acc
  import split_pkg::*;
#(
  parameter int VAR_W = DEF_VAR_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic [ACC_W-1:0]          acc,
  input  logic                      sat,
  input  logic [VAR_W-1:0]          data,
  input  logic [width_w(VAR_W)-1:0] width,
  output logic [ACC_W-1:0]          acc_next,
  output logic                      sat_next
`ifdef SPLIT_PARITY_EN
  ,
  input  logic                      par,
  output logic                      par_next
`endif
);

  logic [VAR_W-1:0] mask;
  logic [VAR_W-1:0] masked;
  logic [ACC_W:0]   sum;

  // Mask to the declared width (widths >= VAR_W keep the whole word), then add with a carry-out saturation.
  always_comb begin
    if (int'(width) >= VAR_W) mask = '1;
    else                      mask = (VAR_W'(1) << width) - VAR_W'(1);
    masked   = data & mask;
    sum      = {1'b0, acc} + (ACC_W+1)'(masked);
    acc_next = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
    sat_next = sat | sum[ACC_W];
`ifdef SPLIT_PARITY_EN
    par_next = par ^ (^masked);
`endif
  end

endmodule

// File: rtl/split_eval_seq.sv
// rtl/split_eval_seq.sv - streaming split evaluator: masked saturating sum, framing check, verdict handshake; optional SPLIT_PARITY_EN
module split_eval_seq
  import split_pkg::*;
#(
  parameter int          NUM_VARS = 30,
  parameter int          VAR_W    = DEF_VAR_W,
  parameter int          ACC_W    = DEF_ACC_W,
  parameter logic [63:0] LIMIT    = 64'h1_0000_0000,
  parameter int          PARITY   = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [VAR_W-1:0]             in_data,
  input  logic [width_w(VAR_W)-1:0]    in_width,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         x,
  output logic                         err,
  output logic [count_w(NUM_VARS)-1:0] out_count
`ifdef SPLIT_PARITY_EN
  ,
  output logic                         par
`endif
);

  localparam int            CW   = count_w(NUM_VARS);
  localparam logic [CW-1:0] FULL = CW'(NUM_VARS);

  state_t           state, state_n;
  logic [ACC_W-1:0] acc, acc_n, sum_acc;
  logic             sat, sat_n, sum_sat;
  logic [CW-1:0]    cnt, cnt_n;
  logic             x_n, err_n;
`ifdef SPLIT_PARITY_EN
  logic             par_n, sum_par;
`endif

  assign out_count = cnt;

  // The accumulator is zero in IDLE, so the same adder serves as the first-beat load.
  split_mask_acc #(
    .VAR_W (VAR_W),
    .ACC_W (ACC_W)
  ) u_mask_acc (
    .acc      (acc),
    .sat      (sat),
    .data     (in_data),
    .width    (in_width),
    .acc_next (sum_acc),
    .sat_next (sum_sat)
`ifdef SPLIT_PARITY_EN
    ,
    .par      (par),
    .par_next (sum_par)
`endif
  );

  // Next state, datapath updates and handshake outputs; the verdict is latched on entry to DONE.
  always_comb begin
    state_n   = state;
    acc_n     = acc;
    sat_n     = sat;
    cnt_n     = cnt;
    x_n       = x;
    err_n     = err;
    in_ready  = 1'b0;
    out_valid = 1'b0;
`ifdef SPLIT_PARITY_EN
    par_n     = par;
`endif
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_n   = sum_acc;
          sat_n   = sum_sat;
          cnt_n   = CW'(1);
`ifdef SPLIT_PARITY_EN
          par_n   = sum_par;
`endif
          state_n = in_last ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          cnt_n = cnt + CW'(1);
          if (cnt == FULL) begin
            // Overrun beat: counted so the error shows, but its value is dropped.
            state_n = DONE;
          end else begin
            acc_n = sum_acc;
            sat_n = sum_sat;
`ifdef SPLIT_PARITY_EN
            par_n = sum_par;
`endif
            if (in_last) state_n = DONE;
          end
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_n = IDLE;
          acc_n   = '0;
          sat_n   = 1'b0;
          cnt_n   = '0;
          x_n     = 1'b0;
          err_n   = 1'b0;
`ifdef SPLIT_PARITY_EN
          par_n   = 1'b0;
`endif
        end
      end
      default: state_n = IDLE;
    endcase
    if (state != DONE && state_n == DONE) begin
      err_n = (cnt_n != FULL);
      x_n   = !err_n && !sat_n && (64'(acc_n) <= LIMIT)
`ifdef SPLIT_PARITY_EN
              && (par_n == PARITY[0])
`endif
              ;
    end
  end

  // State and datapath registers; rst discards any split or verdict in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      sat   <= 1'b0;
      cnt   <= '0;
      x     <= 1'b0;
      err   <= 1'b0;
`ifdef SPLIT_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      acc   <= acc_n;
      sat   <= sat_n;
      cnt   <= cnt_n;
      x     <= x_n;
      err   <= err_n;
`ifdef SPLIT_PARITY_EN
      par   <= par_n;
`endif
    end
  end

endmodule

// File: tb/tb_split_eval_seq.sv
// tb/tb_split_eval_seq.sv - table, hand-sequence and random checks of split_eval_seq against a sum model
module tb_split_eval_seq;
  import split_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Group A: NUM_VARS=3 with ACC_W=40/LIMIT=100 (dut_a) and ACC_W=33/huge LIMIT (dut_s)
  logic        a_valid = 0, a_last = 0, a_oready = 0;
  logic [31:0] a_data = 0;
  logic [5:0]  a_width = 0;
  logic        ra, va, xa, ea, rs, vs, xs, es;
  logic [count_w(3)-1:0] ca, cs;

  // Group B: NUM_VARS=2 LIMIT=14 (b), NUM_VARS=2 LIMIT=15 (c), NUM_VARS=1 LIMIT=15 (d)
  logic        b_valid = 0, b_last = 0, b_oready = 0;
  logic [31:0] b_data = 0;
  logic [5:0]  b_width = 0;
  logic        rb, vb, xb, eb, rc, vc, xc, ec_, rd, vd, xd, ed;
  logic [count_w(2)-1:0] cb, cc;
  logic [count_w(1)-1:0] cd;
`ifdef SPLIT_PARITY_EN
  logic par_a, par_s, par_b, par_c, par_d, par_p1, par_p0;
  logic rp1, vp1, xp1, ep1, rp0, vp0, xp0, ep0;
  logic [count_w(2)-1:0] cp1, cp0;
`endif

  split_eval_seq #(.NUM_VARS(3), .VAR_W(32), .ACC_W(40), .LIMIT(64'd100)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(ra), .in_data(a_data), .in_width(a_width),
    .in_last(a_last), .out_valid(va), .out_ready(a_oready), .x(xa), .err(ea), .out_count(ca)
`ifdef SPLIT_PARITY_EN
    , .par(par_a)
`endif
  );
  split_eval_seq #(.NUM_VARS(3), .VAR_W(32), .ACC_W(33), .LIMIT(64'hFFFF_FFFF_FFFF)) dut_s (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(rs), .in_data(a_data), .in_width(a_width),
    .in_last(a_last), .out_valid(vs), .out_ready(a_oready), .x(xs), .err(es), .out_count(cs)
`ifdef SPLIT_PARITY_EN
    , .par(par_s)
`endif
  );
  split_eval_seq #(.NUM_VARS(2), .VAR_W(32), .ACC_W(40), .LIMIT(64'd14)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(rb), .in_data(b_data), .in_width(b_width),
    .in_last(b_last), .out_valid(vb), .out_ready(b_oready), .x(xb), .err(eb), .out_count(cb)
`ifdef SPLIT_PARITY_EN
    , .par(par_b)
`endif
  );
  split_eval_seq #(.NUM_VARS(2), .VAR_W(32), .ACC_W(40), .LIMIT(64'd15)) dut_c (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(rc), .in_data(b_data), .in_width(b_width),
    .in_last(b_last), .out_valid(vc), .out_ready(b_oready), .x(xc), .err(ec_), .out_count(cc)
`ifdef SPLIT_PARITY_EN
    , .par(par_c)
`endif
  );
  split_eval_seq #(.NUM_VARS(1), .VAR_W(32), .ACC_W(40), .LIMIT(64'd15)) dut_d (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(rd), .in_data(b_data), .in_width(b_width),
    .in_last(b_last), .out_valid(vd), .out_ready(b_oready), .x(xd), .err(ed), .out_count(cd)
`ifdef SPLIT_PARITY_EN
    , .par(par_d)
`endif
  );
`ifdef SPLIT_PARITY_EN
  split_eval_seq #(.NUM_VARS(2), .PARITY(1)) dut_p1 (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(rp1), .in_data(b_data), .in_width(b_width),
    .in_last(b_last), .out_valid(vp1), .out_ready(b_oready), .x(xp1), .err(ep1), .out_count(cp1), .par(par_p1)
  );
  split_eval_seq #(.NUM_VARS(2), .PARITY(0)) dut_p0 (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(rp0), .in_data(b_data), .in_width(b_width),
    .in_last(b_last), .out_valid(vp0), .out_ready(b_oready), .x(xp0), .err(ep0), .out_count(cp0), .par(par_p0)
  );
`endif

  // Current split stimulus, shared by model and drivers
  logic [31:0] bd[8];
  logic [5:0]  bw[8];
  bit          bl[8];
  int          nb;

  typedef struct {
    int          n;
    logic [31:0] d[4];
    logic [5:0]  w[4];
    bit          l[4];
    bit          x;
    bit          e;
    int          c;
  } vec_t;
  vec_t tab[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] masked(input logic [31:0] d, input logic [5:0] w);
    return (w >= 6'd32) ? 64'(d) : 64'(d) % (64'd1 << w);
  endfunction

  // Exact-sum model: beats taken until last or the (nv+1)th, which is counted but not summed.
  function automatic void model(input int nv, input int accw, input logic [63:0] lim, input int par_req,
                                output bit ex, output bit ee, output int ecnt, output bit ep);
    logic [63:0] sum, m;
    bit fin;
    sum = 0; ecnt = 0; ep = 0; fin = 0;
    for (int i = 0; i < nb && !fin; i++) begin
      ecnt++;
      if (ecnt == nv + 1) fin = 1;
      else begin
        m = masked(bd[i], bw[i]);
        sum += m;
        ep ^= ^m;
        fin = bl[i];
      end
    end
    ee = (ecnt != nv);
    ex = !ee && (sum < (64'd1 << accw)) && (sum <= lim) && (par_req < 0 || ep == par_req[0]);
  endfunction

  task automatic run_a(input string tag, input int hold, input bit has_tab, input bit tx, input bit te, input int tc);
    bit mx, me, sx, se, mp;
    int mc, sc;
    model(3, 40, 64'd100, -1, mx, me, mc, mp);
    model(3, 33, 64'hFFFF_FFFF_FFFF, -1, sx, se, sc, mp);
    chk({tag, ".in_ready"}, ra, 1);
    for (int i = 0; i < mc; i++) begin
      a_data = bd[i]; a_width = bw[i]; a_last = bl[i]; a_valid = 1;
      if (i == mc - 1) chk({tag, ".early_valid"}, va, 0);
      @(posedge clk); #1;
    end
    a_valid = 0; a_last = 0;
    chk({tag, ".a.valid"}, va, 1);
    chk({tag, ".a.x"}, xa, mx);
    chk({tag, ".a.err"}, ea, me);
    chk({tag, ".a.count"}, ca, mc);
    chk({tag, ".s.valid"}, vs, 1);
    chk({tag, ".s.x"}, xs, sx);
    chk({tag, ".s.count"}, cs, sc);
    if (has_tab) begin
      chk({tag, ".tab.x"}, xa, tx);
      chk({tag, ".tab.err"}, ea, te);
      chk({tag, ".tab.count"}, ca, tc);
    end
    for (int h = 0; h < hold; h++) begin
      a_valid = 1; a_data = 32'hFFFF_FFFF; a_width = 32; a_last = 1;
      @(posedge clk); #1;
      chk({tag, ".hold.valid"}, va, 1);
      chk({tag, ".hold.in_ready"}, ra, 0);
      chk({tag, ".hold.x"}, xa, mx);
      chk({tag, ".hold.count"}, ca, mc);
    end
    a_valid = 0; a_last = 0; a_oready = 1;
    @(posedge clk); #1;
    a_oready = 0;
    chk({tag, ".release.valid"}, va, 0);
    chk({tag, ".release.in_ready"}, ra, 1);
    chk({tag, ".release.count"}, ca, 0);
  endtask

  task automatic run_b(input string tag);
    bit bx, be, cx, ce, dx, de, mp;
    int bc, ccn, dc;
    model(2, 40, 64'd14, -1, bx, be, bc, mp);
    model(2, 40, 64'd15, -1, cx, ce, ccn, mp);
    model(1, 40, 64'd15, -1, dx, de, dc, mp);
    for (int i = 0; i < bc; i++) begin
      b_data = bd[i]; b_width = bw[i]; b_last = bl[i]; b_valid = 1;
      @(posedge clk); #1;
    end
    b_valid = 0; b_last = 0;
    chk({tag, ".b.valid"}, vb, 1);
    chk({tag, ".b.x"}, xb, bx);
    chk({tag, ".b.err"}, eb, be);
    chk({tag, ".b.count"}, cb, bc);
    chk({tag, ".c.x"}, xc, cx);
    chk({tag, ".c.err"}, ec_, ce);
    chk({tag, ".d.valid"}, vd, 1);
    chk({tag, ".d.x"}, xd, dx);
    chk({tag, ".d.err"}, ed, de);
    chk({tag, ".d.count"}, cd, dc);
`ifdef SPLIT_PARITY_EN
    begin
      bit px, pe; int pc;
      model(2, 40, 64'h1_0000_0000, 1, px, pe, pc, mp);
      chk({tag, ".p1.x"}, xp1, px);
      chk({tag, ".p1.par"}, par_p1, mp);
      model(2, 40, 64'h1_0000_0000, 0, px, pe, pc, mp);
      chk({tag, ".p0.x"}, xp0, px);
    end
`endif
    b_oready = 1;
    @(posedge clk); #1;
    b_oready = 0;
    chk({tag, ".b.release"}, vb, 0);
  endtask

  task automatic load_tab(input int t);
    nb = tab[t].n;
    for (int i = 0; i < 4; i++) begin
      bd[i] = tab[t].d[i]; bw[i] = tab[t].w[i]; bl[i] = tab[t].l[i];
    end
  endtask

  initial begin
    tab[0] = '{3, '{32'd5, 32'd7, 32'd9, 32'd0}, '{6'd32, 6'd32, 6'd32, 6'd0}, '{0, 0, 1, 0}, 1, 0, 3};
    tab[1] = '{2, '{32'd1, 32'd2, 32'd0, 32'd0}, '{6'd32, 6'd32, 6'd0, 6'd0}, '{0, 1, 0, 0}, 0, 1, 2};
    tab[2] = '{4, '{32'd1, 32'd2, 32'd3, 32'd4}, '{6'd32, 6'd32, 6'd32, 6'd32}, '{0, 0, 0, 0}, 0, 1, 4};
    tab[3] = '{4, '{32'd1, 32'd2, 32'd3, 32'd4}, '{6'd32, 6'd32, 6'd32, 6'd32}, '{0, 0, 0, 1}, 0, 1, 4};
    tab[4] = '{3, '{32'd50, 32'd50, 32'd1, 32'd0}, '{6'd32, 6'd32, 6'd32, 6'd0}, '{0, 0, 1, 0}, 0, 0, 3};
    tab[5] = '{3, '{32'd100, 32'hFFFF, 32'h8, 32'd0}, '{6'd32, 6'd0, 6'd3, 6'd0}, '{0, 0, 1, 0}, 1, 0, 3};
    tab[6] = '{3, '{32'hABC3, 32'hFFFF_FFFF, 32'h1234_5678, 32'd0}, '{6'd4, 6'd5, 6'd6, 6'd0}, '{0, 0, 1, 0}, 1, 0, 3};
    tab[7] = '{3, '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd0}, '{6'd32, 6'd32, 6'd32, 6'd0}, '{0, 0, 1, 0}, 0, 0, 3};
    tab[8] = '{3, '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0}, '{6'd32, 6'd32, 6'd32, 6'd0}, '{0, 0, 1, 0}, 0, 0, 3};
    tab[9] = '{3, '{32'h40, 32'h20, 32'd4, 32'd0}, '{6'd63, 6'd33, 6'd32, 6'd0}, '{0, 0, 1, 0}, 1, 0, 3};

    repeat (2) @(posedge clk);
    #1;
    chk("reset.in_ready", ra, 1);
    chk("reset.out_valid", va, 0);
    chk("reset.x", xa, 0);
    chk("reset.err", ea, 0);
    chk("reset.count", ca, 0);
    rst = 0;

    for (int t = 0; t < 10; t++) begin
      load_tab(t);
      run_a($sformatf("tab%0d", t), 0, 1, tab[t].x, tab[t].e, tab[t].c);
    end

    load_tab(0);
    run_a("backpressure", 5, 1, 1, 0, 3);

    a_valid = 1; a_data = 32'd1000; a_width = 32; a_last = 0;
    repeat (2) @(posedge clk);
    #1;
    a_valid = 0; rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("midreset.out_valid", va, 0);
    chk("midreset.in_ready", ra, 1);
    chk("midreset.count", ca, 0);
    load_tab(0);
    run_a("after_reset", 0, 1, 1, 0, 3);

    nb = 2;
    bd[0] = 32'hFF; bw[0] = 4; bl[0] = 0;
    bd[1] = 32'hFFFF_FFFF; bw[1] = 0; bl[1] = 1;
    run_b("mask");
    nb = 1;
    bd[0] = 32'd7; bw[0] = 32; bl[0] = 1;
    run_b("single");
    nb = 2;
    bd[0] = 32'h3; bw[0] = 32; bl[0] = 0;
    bd[1] = 32'h1; bw[1] = 32; bl[1] = 1;
    run_b("parity");

    for (int k = 0; k < 40; k++) begin
      nb = $urandom_range(1, 5);
      for (int i = 0; i < nb; i++) begin
        bd[i] = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 60));
        bw[i] = 6'($urandom_range(0, 34));
        bl[i] = (i == nb - 1) ? 1'b1 : ($urandom_range(0, 5) == 0);
      end
      run_a($sformatf("rnd%0d", k), $urandom_range(0, 2), 0, 0, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/split_eval_seq.md
Name: split_eval_seq

Overview:
- Sequential successor to the fixed-port, constant-output split modules in the solver flow.
- Takes a split's variables as a stream, one variable per beat, over a valid/ready handshake.
- Masks each variable to its declared width and accumulates a saturating sum.
- Reports a per-split verdict `x` with a result handshake.
- Variable count, variable width and bound are parameters, so one module covers every split.

Parameters:
- NUM_VARS, 30, number of variables per split; must be at least 1.
- VAR_W, 32, maximum variable width in bits.
- ACC_W, 40, accumulator width; must be at least VAR_W.
- LIMIT, 2**32, bound; x=1 requires sum <= LIMIT.
- PARITY, 0, required XOR of all masked bits; used only with the optional feature.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  variable beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  VAR_W  variable value.
- in_width  in  $clog2(VAR_W+1)  declared width of this variable.
- in_last  in  1  final variable of the split.
- out_valid  out  1  verdict valid.
- out_ready  in  1  consumer accepts the verdict.
- x  out  1  verdict: 1 means constraint satisfied.
- err  out  1  framing error: beat count is not NUM_VARS.
- out_count  out  $clog2(NUM_VARS+1)+1  beats accepted in this split.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; rst wins over every other event in the same cycle.
- Reset values:
  - state = IDLE; in_ready = 1; out_valid = 0; x = 0; err = 0; out_count = 0.
  - Accumulator = 0; parity register = 0.
- Reset mid-split or mid-result: the partial split is discarded and no verdict is produced.
- States: IDLE, ACCUM, DONE.
- Accept: a beat is accepted when in_valid && in_ready.
- Masking:
  - masked = in_data & ((1 << in_width) - 1).
  - in_width = 0 gives 0.
  - in_width >= VAR_W gives the full in_data.
- Accumulation:
  - acc_next = acc + zero-extended masked.
  - Saturates at 2**ACC_W - 1, with a sticky saturation flag.
- Counting: out_count increments per accepted beat and saturates at NUM_VARS+1.
- IDLE:
  - in_ready = 1.
  - An accepted beat loads acc = masked and count = 1.
  - Goes to DONE if in_last, else to ACCUM.
- ACCUM:
  - in_ready = 1.
  - Each accepted beat adds to acc.
  - Goes to DONE on in_last, or when the beat would be number NUM_VARS+1. That beat is counted but not added (overrun).
- DONE:
  - in_ready = 0; out_valid = 1.
  - x, err and out_count are held stable.
  - On out_ready, goes to IDLE and clears the accumulator and count.
  - A new beat can be accepted on the next cycle.
- Verdict, registered on entry to DONE:
  - err = (count != NUM_VARS).
  - x = !err && !saturated && (acc <= LIMIT).
- Latency: out_valid rises exactly one cycle after the in_last beat is accepted.
- Throughput: at most one split per (number of beats + 1) cycles when out_ready is held high.
- Boundaries:
  - NUM_VARS = 1: a single last beat goes IDLE -> DONE.
  - A last beat that is also the overrun beat reports err = 1.
  - in_valid while in DONE is ignored (not accepted).

Optional Feature:
- Macro: SPLIT_PARITY_EN.
- When defined:
  - A parity register accumulates the XOR-reduction of each masked beat.
  - x additionally requires parity == PARITY[0].
  - A port `par` (out, 1) exposes the parity, valid with out_valid.
- When undefined:
  - No parity logic and no `par` port.
  - x depends only on err, saturation and LIMIT.

Decomposition:
- Shared package split_pkg:
  - State enum: IDLE, ACCUM, DONE.
  - Width helper functions: count width and in_width width.
  - Default constants: VAR_W, ACC_W.
- One sub-module, split_mask_acc: masking plus the saturating add and its flag, purely combinational.
- The FSM and output registers stay in split_eval_seq.

Test Plan:
- Nominal: NUM_VARS=3, beats (5,w=32), (7,w=32), (9,w=32,last), LIMIT=100 -> out_valid one cycle after the last beat; x=1, err=0, out_count=3.
- Masking: NUM_VARS=2, beats (0xFF,w=4), (0xFFFFFFFF,w=0,last), LIMIT=14 -> x=0 because the sum is 15 > 14. Same stimulus with LIMIT=15 -> x=1.
- Framing:
  - Short split: last on beat 2 of NUM_VARS=3 -> err=1, x=0, out_count=2.
  - Long split: 4 beats with no last -> DONE after beat 4, err=1, out_count=4.
- Saturation: ACC_W=33, VAR_W=32, two beats of 0xFFFFFFFF then a third beat of 2 -> saturated; x=0 regardless of LIMIT.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles -> in_ready=0 and outputs stable; release -> IDLE next cycle.
  - Assert rst during ACCUM -> next cycle in IDLE, out_valid=0, and the next split is evaluated from zero.
- SPLIT_PARITY_EN, PARITY=1: beats 0x3, 0x1 (last) -> par=1, x=1. With PARITY=0 -> x=0.
